// File: rtl/sr_imem_loader.sv
// sr_imem_loader: instruction RAM for the schoolRISCV core with a byte-stream image loader.
// Fetch path is combinational (0 cycles); a loaded word is visible on imData after its write edge.
// Loader accepts at most one byte per cycle (ld_valid & ld_ready) and holds the core in reset while loading.
//
// Ports:
//   clk, rst           - clock and asynchronous active-high reset
//   imAddr / imData    - core fetch port (word address in, instruction word out)
//   ld_start           - single-cycle request to begin a load session
//   ld_valid/ld_data   - loader byte stream in; ld_ready says a byte can be taken
//   ld_busy/ld_done    - session in progress / one-cycle success pulse
//   ld_error           - sticky error (bad header size or checksum) until the next ld_start
//   cpu_rst_n          - registered active-low reset to the core
module sr_imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imAddr,
  output logic [31:0] imData,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_error,
  output logic        cpu_rst_n
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [23:0]           asm_q, asm_d;     // bytes b2,b1,b0 of the word being assembled
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  mem_we;
  logic                  xfer;
  logic [15:0]           n_full;

  logic [31:0] mem [DEPTH];

  assign ld_ready  = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
  assign ld_busy   = ld_ready;
  assign ld_done   = (state_q == S_DONE);
  assign ld_error  = (state_q == S_ERROR);
  assign cpu_rst_n = cpu_rst_n_q;

  assign xfer   = ld_valid && ld_ready;
  assign n_full = {ld_data, n_q[7:0]};

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    waddr_d     = waddr_q;
    bcnt_d      = bcnt_q;
    csum_d      = csum_q;
    asm_d       = asm_q;
    cpu_rst_n_d = cpu_rst_n_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (ld_start) begin
          state_d     = S_HDR0;
          waddr_d     = '0;
          bcnt_d      = '0;
          csum_d      = '0;
          cpu_rst_n_d = 1'b0;
        end else if (state_q == S_IDLE) begin
          cpu_rst_n_d = 1'b1;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          n_d[7:0] = ld_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d = n_full;
          if (32'(n_full) > DEPTH)  state_d = S_ERROR;
          else if (n_full == 16'd0) state_d = S_CSUM;
          else                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ ld_data;
          asm_d  = {ld_data, asm_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          // 4th byte completes the word: it goes straight to RAM from ld_data.
          if (bcnt_q == 2'd3) begin
            mem_we  = 1'b1;
            waddr_d = waddr_q + 1'b1;
            if (32'(waddr_q) + 32'd1 == 32'(n_q)) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (ld_data == csum_q) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        cpu_rst_n_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      waddr_q     <= '0;
      bcnt_q      <= '0;
      csum_q      <= '0;
      asm_q       <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      waddr_q     <= waddr_d;
      bcnt_q      <= bcnt_d;
      csum_q      <= csum_d;
      asm_q       <= asm_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // RAM has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr_q[ADDR_WIDTH-1:0]] <= {ld_data, asm_q};
  end

  always_comb begin
    imData = NOP_WORD;
    if (imAddr[31:ADDR_WIDTH] == '0) imData = mem[imAddr[ADDR_WIDTH-1:0]];
  end

endmodule

// File: tb/tb_sr_imem_loader.sv
module tb_sr_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_error;
  logic        cpu_rst_n;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit hold_valid = 1'b0;

  logic [31:0] model_mem [256];
  logic [7:0]  img_q [$];
  logic [31:0] wq [$];

  sr_imem_loader dut (
    .clk(clk), .rst(rst), .imAddr(imAddr), .imData(imData),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_error(ld_error), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ld_done === 1'b1) done_cnt++;

  // Image = N (16-bit LE), 4N data bytes (words LE), XOR of data bytes.
  task automatic build_image(input bit corrupt);
    int n;
    logic [7:0] cs;
    logic [7:0] b;
    n = wq.size();
    img_q = {};
    img_q.push_back(n[7:0]);
    img_q.push_back(n[15:8]);
    cs = 8'h00;
    foreach (wq[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = wq[i][8*k +: 8];
        img_q.push_back(b);
        cs = cs ^ b;
      end
    end
    img_q.push_back(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic commit_model();
    foreach (wq[i]) model_mem[i] = wq[i];
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 256; i++) begin
      imAddr = i;
      #1;
      checks++;
      if (imData !== model_mem[i]) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h expected %h", tag, i, imData, model_mem[i]);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    bit acc;
    waited = 0;
    acc = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    ld_valid = 1'b1;
    ld_data  = b;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (ld_ready === 1'b1) begin
        acc = 1'b1;
        checks++;
        if (cpu_rst_n !== 1'b0 || ld_busy !== 1'b1) begin
          errors++;
          $display("FAIL during_load: cpu_rst_n=%b ld_busy=%b expected 0/1", cpu_rst_n, ld_busy);
        end
      end
      @(posedge clk); #1;
      waited++;
    end
    ld_valid = hold_valid;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL byte_timeout: byte %h not accepted in %0d cycles", b, waited);
    end
  endtask

  task automatic send_image(input bit gaps);
    foreach (img_q[i]) send_byte(img_q[i], gaps);
  endtask

  task automatic start_load(input string tag);
    @(posedge clk); #1;
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
    checks++;
    if (ld_busy !== 1'b1 || ld_ready !== 1'b1 || cpu_rst_n !== 1'b0 || ld_error !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b ready=%b cpu_rst_n=%b err=%b expected 1/1/0/0",
               tag, ld_busy, ld_ready, cpu_rst_n, ld_error);
    end
  endtask

  // Called right after the checksum transfer edge of a good image.
  task automatic finish_ok(input string tag, input int d0);
    checks++;
    if (ld_done !== 1'b1 || cpu_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle: done=%b cpu_rst_n=%b expected 1/0", tag, ld_done, cpu_rst_n);
    end
    @(posedge clk); #1;
    checks++;
    if (ld_done !== 1'b0 || cpu_rst_n !== 1'b1 || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b cpu_rst_n=%b busy=%b expected 0/1/0",
               tag, ld_done, cpu_rst_n, ld_busy);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt - d0);
    end
  endtask

  task automatic check_error_state(input string tag);
    checks++;
    if (ld_error !== 1'b1 || ld_ready !== 1'b0 || cpu_rst_n !== 1'b0 || ld_done !== 1'b0) begin
      errors++;
      $display("FAIL %s error_state: err=%b ready=%b cpu_rst_n=%b done=%b expected 1/0/0/0",
               tag, ld_error, ld_ready, cpu_rst_n, ld_done);
    end
  endtask

  task automatic recover_empty(input string tag);
    int d0;
    start_load(tag);
    wq = {};
    build_image(1'b0);
    d0 = done_cnt;
    send_image(1'b0);
    finish_ok(tag, d0);
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; imAddr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cpu_rst_n !== 1'b0 || ld_ready !== 1'b0 || ld_busy !== 1'b0 ||
        ld_done !== 1'b0 || ld_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: cpu_rst_n=%b ready=%b busy=%b done=%b err=%b expected all 0",
               cpu_rst_n, ld_ready, ld_busy, ld_done, ld_error);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (cpu_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: cpu_rst_n=%b expected 0", cpu_rst_n);
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cpu_rst_n=%b expected 1", cpu_rst_n);
    end
  endtask

  task automatic test_full_load();
    int d0;
    wq = {};
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
    build_image(1'b0);
    start_load("full");
    d0 = done_cnt;
    send_image(1'b1);
    finish_ok("full", d0);
    commit_model();
    check_mem("full");
  endtask

  task automatic test_good_load();
    int d0;
    img_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA1, 8'h00, 8'h70};
    wq = '{32'h0050_0093, 32'h00A1_0113};
    start_load("good");
    d0 = done_cnt;
    send_image(1'b1);
    finish_ok("good", d0);
    commit_model();
    imAddr = 32'd1;
    #1;
    checks++;
    if (imData !== 32'h00A1_0113) begin
      errors++;
      $display("FAIL good_fetch1: got %h expected 00a10113", imData);
    end
    check_mem("good");
  endtask

  task automatic test_bad_csum();
    img_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA1, 8'h00, 8'h71};
    wq = '{32'h0050_0093, 32'h00A1_0113};
    start_load("badcs");
    send_image(1'b0);
    check_error_state("badcs");
    repeat (3) @(posedge clk);
    #1;
    check_error_state("badcs_sticky");
    commit_model();
    recover_empty("badcs_recover");
    check_mem("badcs");
  endtask

  task automatic test_zero_words();
    recover_empty("zero");
    check_mem("zero");
  endtask

  task automatic test_oversize();
    start_load("over");
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check_error_state("over");
    recover_empty("over_recover");
    check_mem("over");
  endtask

  task automatic test_out_of_range();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) a = 32'h100;
      else if (i == 1) a = 32'hFFFF_FFFF;
      else begin
        a = $urandom;
        if (a < 32'h100) a = a + 32'h100;
      end
      imAddr = a;
      #1;
      checks++;
      if (imData !== 32'h0000_0013) begin
        errors++;
        $display("FAIL oor_fetch addr %h: got %h expected 00000013", a, imData);
      end
    end
    imAddr = 32'hFF;
    #1;
    checks++;
    if (imData !== model_mem[255]) begin
      errors++;
      $display("FAIL top_word: got %h expected %h", imData, model_mem[255]);
    end
  endtask

  task automatic test_mid_reset();
    wq = {};
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    build_image(1'b0);
    start_load("midrst");
    for (int i = 0; i < 7; i++) send_byte(img_q[i], 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (ld_busy !== 1'b0 || ld_ready !== 1'b0 || cpu_rst_n !== 1'b0 || ld_error !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b ready=%b cpu_rst_n=%b err=%b expected all 0",
               ld_busy, ld_ready, cpu_rst_n, ld_error);
    end
    model_mem[0] = wq[0];
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cpu_rst_n !== 1'b1 || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: cpu_rst_n=%b busy=%b expected 1/0", cpu_rst_n, ld_busy);
    end
    check_mem("midrst");
  endtask

  task automatic test_backpressure();
    int d0;
    wq = {};
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    build_image(1'b0);
    start_load("bp");
    d0 = done_cnt;
    for (int i = 0; i < img_q.size() - 1; i++) send_byte(img_q[i], 1'b0);
    hold_valid = 1'b1;
    send_byte(img_q[img_q.size() - 1], 1'b0);
    ld_data = $urandom;
    finish_ok("bp", d0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ld_ready !== 1'b0 || ld_busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_idle_accept: ready=%b busy=%b expected 0/0", ld_ready, ld_busy);
      end
    end
    @(posedge clk); #1;
    hold_valid = 1'b0;
    ld_valid = 1'b0;
    commit_model();
    check_mem("bp");
  endtask

  task automatic test_random_loads();
    int d0;
    bit bad;
    for (int it = 0; it < 5; it++) begin
      wq = {};
      for (int i = 0; i < $urandom_range(1, 16); i++) wq.push_back($urandom);
      bad = ($urandom_range(0, 3) == 0);
      build_image(bad);
      start_load("rand");
      d0 = done_cnt;
      send_image(1'b1);
      commit_model();
      if (bad) begin
        check_error_state("rand_bad");
        recover_empty("rand_recover");
      end else begin
        finish_ok("rand", d0);
      end
      check_mem("rand");
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_good_load();
    test_bad_csum();
    test_zero_words();
    test_oversize();
    test_out_of_range();
    test_mid_reset();
    test_backpressure();
    test_random_loads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
